// File: rtl/mul_pkg.sv
// Shared types and constants for the iterative 32x32 multiplier built on MUL16.
package mul_pkg;

  localparam int HALF_W = 16;
  localparam int FULL_W = 32;
  localparam int PROD_W = 64;
  localparam int SH_W   = 6;

  // Sequencer states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MUL   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef logic [1:0] step_t;

  // Left shift applied to each half-product when it is accumulated.
  localparam logic [SH_W-1:0] SHIFT_STEP0 = 6'd0;
  localparam logic [SH_W-1:0] SHIFT_STEP1 = 6'd16;
  localparam logic [SH_W-1:0] SHIFT_STEP2 = 6'd16;
  localparam logic [SH_W-1:0] SHIFT_STEP3 = 6'd32;

  function automatic logic [SH_W-1:0] step_shift(input step_t s);
    case (s)
      2'd0:    return SHIFT_STEP0;
      2'd1:    return SHIFT_STEP1;
      2'd2:    return SHIFT_STEP2;
      default: return SHIFT_STEP3;
    endcase
  endfunction

endpackage

// File: rtl/mul32_seq_mul16.sv
// MUL16: combinational 16x16 unsigned multiplier. Partial products are folded
// through a chain of 3:2 carry-save compressors; one carry-propagate add at the end.
module MUL16
  import mul_pkg::*;
(
  input  logic [HALF_W-1:0] a_i,
  input  logic [HALF_W-1:0] b_i,
  output logic [FULL_W-1:0] p_o
);

  logic [FULL_W-1:0] sum_v;
  logic [FULL_W-1:0] carry_v;
  logic [FULL_W-1:0] pp_v;
  logic [FULL_W-1:0] nsum_v;

  // Carry-save reduction of the 16 partial-product rows. The product fits in
  // 32 bits, so carries dropped off the top of the 32-bit rows never matter.
  always_comb begin
    sum_v   = '0;
    carry_v = '0;
    pp_v    = '0;
    nsum_v  = '0;
    for (int i = 0; i < HALF_W; i++) begin
      pp_v    = b_i[i] ? (FULL_W'(a_i) << i) : '0;
      nsum_v  = sum_v ^ carry_v ^ pp_v;
      carry_v = ((sum_v & carry_v) | (sum_v & pp_v) | (carry_v & pp_v)) << 1;
      sum_v   = nsum_v;
    end
    p_o = sum_v + carry_v;
  end

endmodule

// File: rtl/mul32_seq.sv
// mul32_seq: iterative 32x32 unsigned multiplier. Streams the four 16x16
// half-products through one MUL16, registers each, and shift-accumulates them.
module mul32_seq
  import mul_pkg::*;
#(
  parameter bit EARLY_ZERO = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [FULL_W-1:0] a,
  input  logic [FULL_W-1:0] b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] p
);

  state_e            state_q, state_d;
  step_t             step_q, step_d;
  logic [FULL_W-1:0] a_q, a_d;
  logic [FULL_W-1:0] b_q, b_d;
  logic [FULL_W-1:0] pp_q, pp_d;
  logic [SH_W-1:0]   sh_q, sh_d;
  logic              pp_v_q, pp_v_d;
  logic [PROD_W-1:0] acc_q, acc_d;

  logic [HALF_W-1:0] core_a;
  logic [HALF_W-1:0] core_b;
  logic [FULL_W-1:0] core_p;
  logic              accept;
  logic              zero_op;

  assign accept  = in_valid && (state_q == IDLE);
  assign zero_op = EARLY_ZERO && ((a == '0) || (b == '0));

  // Operand select: step bit 0 picks the a half, step bit 1 picks the b half.
  always_comb begin
    core_a = step_q[0] ? a_q[FULL_W-1:HALF_W] : a_q[HALF_W-1:0];
    core_b = step_q[1] ? b_q[FULL_W-1:HALF_W] : b_q[HALF_W-1:0];
  end

  MUL16 u_core (
    .a_i (core_a),
    .b_i (core_b),
    .p_o (core_p)
  );

  // State register; reset is synchronous and wins over every transition.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge inputs, independent of block ordering.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_d unassigned,
    // which would otherwise infer a latch.
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = zero_op ? DONE : MUL;
      MUL:     if (step_q == 2'd3) state_d = DRAIN;
      DRAIN:   state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded straight from the state register.
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  assign p = acc_q;

  // Datapath next-state: operand capture, core result register, accumulator.
  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    step_d = step_q;
    pp_d   = pp_q;
    sh_d   = sh_q;
    pp_v_d = pp_v_q;
    acc_d  = acc_q;
    if (accept) begin
      a_d    = a;
      b_d    = b;
      acc_d  = '0;
      pp_v_d = 1'b0;
      step_d = 2'd0;
    end else begin
      if (pp_v_q) acc_d = acc_q + ({{(PROD_W-FULL_W){1'b0}}, pp_q} << sh_q);
      if (state_q == MUL) begin
        pp_d   = core_p;
        sh_d   = step_shift(step_q);
        pp_v_d = 1'b1;
        step_d = step_q + 2'd1;
      end
      if (state_q == DRAIN) pp_v_d = 1'b0;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      step_q <= '0;
      pp_q   <= '0;
      sh_q   <= '0;
      pp_v_q <= 1'b0;
      acc_q  <= '0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      step_q <= step_d;
      pp_q   <= pp_d;
      sh_q   <= sh_d;
      pp_v_q <= pp_v_d;
      acc_q  <= acc_d;
    end
  end

endmodule

// File: doc/mul32_seq.md
# mul32_seq

Iterative 32x32 unsigned multiplier built around the existing combinational `MUL16` column-compression core. It accepts one operand pair through a valid/ready handshake. It feeds the four 16x16 half-products through a single `MUL16` instance, one per cycle, registers each core result, and shift-accumulates them into a 64-bit product. The result is presented on a valid/ready output. This block is the operand feeder and product consumer that wraps `MUL16` to deliver the 32-bit multiplier at one-quarter the array area.

## Interface
- `EARLY_ZERO`, default 0: when 1, an accepted pair with `a==0` or `b==0` skips the core and completes immediately with `p=0`.

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operand pair valid.
- `in_ready`  out  1  block can accept; high only in IDLE.
- `a`  in  32  multiplicand, unsigned.
- `b`  in  32  multiplier, unsigned.
- `out_valid`  out  1  product valid; held until taken.
- `out_ready`  in  1  downstream accepts product.
- `p`  out  64  product `a*b`, unsigned.

## Operation
- States: IDLE, MUL, DRAIN, DONE.
- IDLE: `in_ready=1`. When `in_valid & in_ready`, capture `a`/`b` into `a_r`/`b_r`, clear `acc`, clear `pp_v`, set `step=0`, and go to MUL.
  - With `EARLY_ZERO=1` and a zero operand, go to DONE with `acc=0` instead.
- MUL: `step` runs 0..3, one per cycle. Core inputs per step:
  - step 0: `a_r[15:0] x b_r[15:0]`, shift 0.
  - step 1: `a_r[31:16] x b_r[15:0]`, shift 16.
  - step 2: `a_r[15:0] x b_r[31:16]`, shift 16.
  - step 3: `a_r[31:16] x b_r[31:16]`, shift 32.
  - Each cycle, register the core output into `pp_r` (32 b), its shift into `sh_r`, and set `pp_v=1`. After step 3, go to DRAIN.
- Accumulate: every cycle with `pp_v=1`, `acc <= acc + ({32'b0,pp_r} << sh_r)`. Arithmetic is 64-bit. Overflow is impossible since the max is 2^64-2^33+1.
- DRAIN: performs the final accumulate, clears `pp_v`, and goes to DONE.
- DONE: `out_valid=1`, `p=acc`. On `out_valid & out_ready`, go to IDLE.
- `in_valid` is ignored outside IDLE. Operands not accepted are not buffered.
- `p` holds its last value in IDLE. It is only meaningful while `out_valid=1`.

## Timing
- Accept at cycle T, i.e. the edge where `in_valid & in_ready`.
- MUL occupies T+1..T+4. Accumulates happen on T+2..T+5, with DRAIN at T+5.
- `out_valid=1` from T+6. Latency is 6 cycles from accept.
- `EARLY_ZERO` path: `out_valid=1` at T+1, `p=0`.
- Output handshake at cycle U: `out_valid=0` and `in_ready=1` at U+1. Minimum issue interval is 7 cycles (2 for early-zero).
- `out_ready` held low: `out_valid` and `p` stay stable indefinitely.
- Reset values: state IDLE, `out_valid=0`, `p/acc=0`, `pp_v=0`, `step=0`, `a_r=b_r=0`. `in_ready=1` in the first cycle after `rst` deasserts.
- Reset mid-operation (any state) abandons the operation. No `out_valid` pulse is produced.
- The core path (`MUL16` plus operand mux) is the one combinational path per cycle, registered at `pp_r`. The adder path is `pp_r`→`acc` only.

## Structure
- Shared package `mul_pkg` holds:
  - the state enum (IDLE/MUL/DRAIN/DONE),
  - `HALF_W=16`, `FULL_W=32`, `PROD_W=64`,
  - the step-to-shift constants (0/16/16/32).
- Sub-module: one `MUL16` instance, reused unmodified. The operand-select mux and accumulator stay in `mul32_seq`.

## Test plan
- `a=0xFFFFFFFF`, `b=0xFFFFFFFF`, `out_ready=1` → `out_valid` at T+6, `p=0xFFFFFFFE00000001`, one-cycle pulse.
- `a=0x0000FFFF`, `b=0xFFFF0000` → `p=0x0000FFFE00010000` (step 2 only nonzero); `a=0x00010000`, `b=0x00010000` → `p=0x0000000100000000`.
- `out_ready` low 3 cycles after `out_valid`, with `in_valid=1` and new operands during the stall → `p` stable, `in_ready=0`, new pair not accepted. After the handshake, `in_ready=1` next cycle and the new pair is accepted.
- `rst` pulsed at T+3 → no `out_valid`. `in_ready=1` the cycle after release. Next op `a=3`, `b=5` → `p=15` at accept+6.
- `EARLY_ZERO=1`, `a=0`, `b=0xDEADBEEF` → `out_valid` at T+1, `p=0`. `EARLY_ZERO=0` with the same pair → T+6, `p=0`.
- 10k random pairs with random `out_ready` stalls → every `p` equals the reference `a*b`, and the count of products equals the count of accepts.
